// File: rtl/usb_tx_encoder.sv
// USB full-speed packet transmitter: SYNC, PID, payload and CRC16 with bit stuffing,
// NRZI line coding and EOP generation. Payload bytes are pulled from the data buffer
// one byte at a time through tx_data/get_tx_data.
module usb_tx_encoder #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned MAX_PAYLOAD  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occ,
  input  logic [7:0] tx_data,
  output logic       get_tx_data,
  output logic       tx_transfer_active,
  output logic       tx_error,
  output logic       dp_out,
  output logic       dm_out
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSync   = 3'd1;
  localparam logic [2:0] StPid    = 3'd2;
  localparam logic [2:0] StData   = 3'd3;
  localparam logic [2:0] StCrcLo  = 3'd4;
  localparam logic [2:0] StCrcHi  = 3'd5;
  localparam logic [2:0] StEopSe0 = 3'd6;
  localparam logic [2:0] StEopJ   = 3'd7;

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Bits of the current byte still to be sent; the bit on the line is not kept here.
  logic [6:0]      shift_q, shift_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [6:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]      pid_byte_q, pid_byte_d;
  logic            is_data_q, is_data_d;
  logic [15:0]     crc_q, crc_d;
  logic [2:0]      ones_q, ones_d;
  logic            stuff_q, stuff_d;
  logic            line_q, line_d;
  logic            dp_q, dp_d;
  logic            dm_q, dm_d;
  logic            get_q, get_d;
  logic            err_q, err_d;
  logic            active_q, active_d;

  logic            accept;
  logic            place;
  logic            nxt_bit;
  logic            line_base;
  logic            crc_upd;
  logic            load;
  logic [7:0]      load_val;

  function automatic logic is_stuff_state(input logic [2:0] s);
    return (s == StPid) || (s == StData) || (s == StCrcLo) || (s == StCrcHi);
  endfunction

  // Next-state: request decode in idle, bit sequencing at each bit-time boundary.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    pid_byte_d = pid_byte_q;
    is_data_d  = is_data_q;
    crc_d      = crc_q;
    ones_d     = ones_q;
    stuff_d    = stuff_q;
    line_d     = line_q;
    dp_d       = dp_q;
    dm_d       = dm_q;
    get_d      = 1'b0;
    err_d      = 1'b0;
    active_d   = active_q;
    accept     = 1'b0;
    place      = 1'b0;
    nxt_bit    = 1'b0;
    line_base  = line_q;
    crc_upd    = 1'b0;
    load       = 1'b0;
    load_val   = 8'h00;

    if (state_q == StIdle) begin
      cnt_d = '0;
      case (tx_packet)
        3'd1, 3'd2: begin
          if (32'(buffer_occ) > MAX_PAYLOAD) begin
            err_d = 1'b1;
          end else begin
            accept     = 1'b1;
            is_data_d  = 1'b1;
            byte_cnt_d = buffer_occ;
            pid_byte_d = (tx_packet == 3'd1) ? 8'hC3 : 8'h4B;
          end
        end
        3'd3, 3'd4, 3'd5: begin
          accept     = 1'b1;
          is_data_d  = 1'b0;
          byte_cnt_d = '0;
          pid_byte_d = (tx_packet == 3'd3) ? 8'hD2 : (tx_packet == 3'd4) ? 8'h5A : 8'h1E;
        end
        3'd6, 3'd7: err_d = 1'b1;
        default: ;
      endcase
      if (accept) begin
        state_d   = StSync;
        active_d  = 1'b1;
        crc_d     = 16'hFFFF;
        stuff_d   = 1'b0;
        line_base = 1'b1;  // NRZI restarts from J for every packet
        load      = 1'b1;
        load_val  = 8'h80;
      end
    end else begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
      if (cnt_q == CntMax) begin
        if (is_stuff_state(state_q) && !stuff_q && (ones_q == 3'd6)) begin
          // Stuff bit: position in the byte and the next buffer read both wait one bit.
          stuff_d = 1'b1;
          place   = 1'b1;
          nxt_bit = 1'b0;
        end else begin
          stuff_d = 1'b0;
          if ((state_q != StEopSe0) && (state_q != StEopJ) && (bit_idx_q != 3'd7)) begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[6:1]};
            nxt_bit   = shift_q[0];
            place     = 1'b1;
            crc_upd   = (state_q == StData);
          end else begin
            case (state_q)
              StSync: begin
                state_d  = StPid;
                load     = 1'b1;
                load_val = pid_byte_q;
              end
              StPid, StData: begin
                if (is_data_q && (byte_cnt_q != 7'd0)) begin
                  state_d    = StData;
                  load       = 1'b1;
                  load_val   = tx_data;
                  get_d      = 1'b1;
                  byte_cnt_d = byte_cnt_q - 7'd1;
                  crc_upd    = 1'b1;
                end else if (is_data_q) begin
                  state_d  = StCrcLo;
                  load     = 1'b1;
                  load_val = ~crc_q[7:0];
                end else begin
                  state_d   = StEopSe0;
                  bit_idx_d = 3'd0;
                  dp_d      = 1'b0;
                  dm_d      = 1'b0;
                end
              end
              StCrcLo: begin
                state_d  = StCrcHi;
                load     = 1'b1;
                load_val = ~crc_q[15:8];
              end
              StCrcHi: begin
                state_d   = StEopSe0;
                bit_idx_d = 3'd0;
                dp_d      = 1'b0;
                dm_d      = 1'b0;
              end
              StEopSe0: begin
                if (bit_idx_q[0]) begin
                  state_d = StEopJ;
                  dp_d    = 1'b1;
                  dm_d    = 1'b0;
                end else begin
                  bit_idx_d = 3'd1;
                end
              end
              StEopJ: begin
                state_d  = StIdle;
                active_d = 1'b0;
                line_d   = 1'b1;
              end
              default: state_d = StIdle;
            endcase
          end
        end
      end
    end

    if (load) begin
      shift_d   = load_val[7:1];
      bit_idx_d = 3'd0;
      nxt_bit   = load_val[0];
      place     = 1'b1;
    end

    if (place) begin
      // NRZI: a 0 toggles the line, a 1 holds it.
      line_d = nxt_bit ? line_base : ~line_base;
      ones_d = (nxt_bit && is_stuff_state(state_d)) ? ones_q + 3'd1 : 3'd0;
      dp_d   = line_d;
      dm_d   = ~line_d;
    end

    // Reflected CRC16 (0x8005 -> 0xA001), payload bits only.
    if (crc_upd) begin
      crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ nxt_bit) ? 16'hA001 : 16'h0000);
    end
  end

  // State register with synchronous reset; reset returns the line to J immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
      pid_byte_q <= '0;
      is_data_q  <= 1'b0;
      crc_q      <= 16'hFFFF;
      ones_q     <= '0;
      stuff_q    <= 1'b0;
      line_q     <= 1'b1;
      dp_q       <= 1'b1;
      dm_q       <= 1'b0;
      get_q      <= 1'b0;
      err_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      pid_byte_q <= pid_byte_d;
      is_data_q  <= is_data_d;
      crc_q      <= crc_d;
      ones_q     <= ones_d;
      stuff_q    <= stuff_d;
      line_q     <= line_d;
      dp_q       <= dp_d;
      dm_q       <= dm_d;
      get_q      <= get_d;
      err_q      <= err_d;
      active_q   <= active_d;
    end
  end

  assign get_tx_data        = get_q;
  assign tx_error           = err_q;
  assign tx_transfer_active = active_q;
  assign dp_out             = dp_q;
  assign dm_out             = dm_q;

endmodule
